// File: rtl/glyph_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_mem_arbiter_pkg
//  Description : Shared types and defaults for the glyph memory arbiter:
//                address/data widths, grant encoding, host command width.
//  Revision    : 1.0  initial release
// ============================================================================
package glyph_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;

    // Owner of the memory port for one cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_HOST = 2'd2
    } grant_t;

    // Host command record: {write, addr, wdata}
    function automatic int cmd_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/glyph_mem_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : host_cmd_fifo
//  Description : Small synchronous in-order FIFO holding host commands.
//                Push is ignored when full, pop is ignored when empty.
//                No pass-through: a pushed entry is visible next cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module host_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign head_data = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_data;
        end
    end

    // Read/write pointer advance; reset flushes the queue
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/glyph_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_mem_arbiter
//  Description : Shares one single-port synchronous glyph RAM between the
//                hard real-time display fetch path (always wins) and a
//                FIFO-buffered host read/write command port.
//                Optional macro GLYPH_BLANK_WRITE_EN: a host write at the
//                FIFO head only issues while compBlank=1.
//  Revision    : 1.0  initial release
// ============================================================================
module glyph_mem_arbiter
    import glyph_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dispReadEn,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic [DATA_W-1:0] dispByte,
    output logic              dispValid,
    input  logic              compBlank,
    input  logic              hostValid,
    output logic              hostReady,
    input  logic              hostWrite,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWData,
    output logic              hostRdValid,
    output logic [DATA_W-1:0] hostRdData,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    output logic [15:0]       hostStallCnt
);

    localparam int c_CMD_W = cmd_width(ADDR_W, DATA_W);

    logic [c_CMD_W-1:0] w_push_cmd;
    logic [c_CMD_W-1:0] w_head_cmd;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_head_write;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_wdata;
    logic               w_head_ok;
    grant_t             w_grant;
    grant_t             w_ret_tag;
    grant_t             r_tag_d1;
    grant_t             r_tag_d2;
    logic [ADDR_W-1:0]  r_last_addr;
    logic [DATA_W-1:0]  r_last_wdata;
    logic [15:0]        r_stall_cnt;

    assign w_push_cmd = {hostWrite, hostAddr, hostWData};
    assign {w_head_write, w_head_addr, w_head_wdata} = w_head_cmd;

`ifdef GLYPH_BLANK_WRITE_EN
    // Writes wait for blanking so glyph updates never tear; reads drain freely
    assign w_head_ok = !w_head_write || compBlank;
`else
    // Head is always eligible; compBlank has no effect in this build
    assign w_head_ok = compBlank | 1'b1;
`endif

    // Ready is held low during reset and whenever the queue is full
    assign hostReady = !reset && !w_full;
    assign w_push    = hostValid && hostReady;
    assign w_pop     = (w_grant == GNT_HOST);

    host_cmd_fifo #(
        .WIDTH (c_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_host_cmd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (w_head_cmd)
    );

    // Fixed-priority grant: display, then host head, else idle
    always_comb begin
        w_grant = GNT_NONE;
        if (!reset) begin
            if (dispReadEn) begin
                w_grant = GNT_DISP;
            end else if (!w_empty && w_head_ok) begin
                w_grant = GNT_HOST;
            end
        end
    end

    // Memory port drive; address and write data hold when idle
    always_comb begin
        memEn    = (w_grant != GNT_NONE);
        memWe    = (w_grant == GNT_HOST) && w_head_write;
        memAddr  = r_last_addr;
        memWData = r_last_wdata;
        case (w_grant)
            GNT_DISP: memAddr = dispAddr;
            GNT_HOST: begin
                memAddr  = w_head_addr;
                memWData = w_head_wdata;
            end
            default: ;
        endcase
    end

    // Only reads produce a return, so host writes enter the pipe as idle
    assign w_ret_tag = (w_grant == GNT_HOST && w_head_write) ? GNT_NONE : w_grant;

    // Remember the last driven address/data for the idle hold behaviour
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_last_addr  <= memAddr;
            r_last_wdata <= memWData;
        end
    end

    // Two-stage return tag; reset cancels anything in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag_d1 <= GNT_NONE;
            r_tag_d2 <= GNT_NONE;
        end else begin
            r_tag_d1 <= w_ret_tag;
            r_tag_d2 <= r_tag_d1;
        end
    end

    // Capture read data one cycle after the access into the owner's register
    always_ff @(posedge clock) begin
        if (reset) begin
            dispByte   <= '0;
            hostRdData <= '0;
        end else begin
            if (r_tag_d1 == GNT_DISP) begin
                dispByte <= memRData;
            end
            if (r_tag_d1 == GNT_HOST) begin
                hostRdData <= memRData;
            end
        end
    end

    assign dispValid   = (r_tag_d2 == GNT_DISP);
    assign hostRdValid = (r_tag_d2 == GNT_HOST);

    // Saturating count of cycles where the host is back-pressured
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (hostValid && !hostReady && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign hostStallCnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/glyph_mem_arbiter.md
Name: glyph_mem_arbiter

Overview:
- Shares one single-port synchronous glyph/character memory between two requesters.
  - Display fetch path: hard real-time, always wins.
  - Host command port: read/write, buffered in a small in-order FIFO.
- Sits between the display character handler (readEn/addOffset fetch) and the glyph RAM.
- Lets the host edit glyphs at run time without ever stalling pixel output.

Parameters:
- ADDR_W, 11, glyph memory address width ({charCode[6:0], rowOffset[3:0]}).
- DATA_W, 8, glyph row width (one romByte).
- FIFO_DEPTH, 4, host command FIFO entries (power of two, >=2).

Ports:
- clock  in  1  system pixel clock
- reset  in  1  synchronous, active-high reset
- dispReadEn  in  1  display fetch request, this cycle
- dispAddr  in  ADDR_W  display fetch address
- dispByte  out  DATA_W  registered fetched glyph row
- dispValid  out  1  dispByte holds data for a request issued 2 cycles earlier
- compBlank  in  1  composite blanking from the VGA timing generator
- hostValid  in  1  host command valid
- hostReady  out  1  FIFO can accept a command
- hostWrite  in  1  1=write, 0=read
- hostAddr  in  ADDR_W  host address
- hostWData  in  DATA_W  host write data
- hostRdValid  out  1  hostRdData valid (1-cycle pulse)
- hostRdData  out  DATA_W  host read return
- memEn  out  1  memory access this cycle
- memWe  out  1  memory write strobe
- memAddr  out  ADDR_W  memory address
- memWData  out  DATA_W  memory write data
- memRData  in  DATA_W  memory read data, valid 1 cycle after a read access
- hostStallCnt  out  16  saturating count of cycles with hostValid && !hostReady

Behaviour:
- Clock/reset: one clock domain (clock). Reset is synchronous and active-high.
  - On reset: FIFO flushed. All outputs 0, except hostReady=1 from the first cycle after reset deasserts.
  - In-flight read returns are discarded.
- Grant per cycle (combinational from the current request and registered FIFO state): GNT_DISP > GNT_HOST > GNT_NONE.
  - GNT_DISP: dispReadEn=1. memEn=1, memWe=0, memAddr=dispAddr.
  - GNT_HOST: dispReadEn=0 and FIFO non-empty. Pop the head.
    - Write command: memWe=1, memAddr/memWData from the head.
    - Read command: memWe=0.
  - GNT_NONE: memEn=0, memWe=0. memAddr/memWData hold their last values.
- Return pipeline: a 2-stage grant tag (d1, d2) is registered every cycle.
  - Display read granted in cycle N: memRData sampled at end of N+1 into dispByte; dispValid=1 in N+2.
  - Host read granted in cycle N: hostRdData loaded likewise; hostRdValid=1 in N+2 for one cycle.
  - dispByte/hostRdData hold their value until the next return.
- FIFO:
  - hostReady = !full. Push on hostValid && hostReady.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - No pass-through: a command pushed in cycle N is poppable from N+1 at the earliest.
  - Commands execute strictly in order. A host read after a host write to the same address returns the new data.
- Display/host hazards: display reads are never forwarded from the FIFO. A display read of an address with a queued write returns the old data.
- Throughput:
  - Display may request every cycle indefinitely; the host then starves and hostReady drops once 4 commands are queued.
  - hostStallCnt increments each stalled cycle and saturates at 16'hFFFF.
- Reset mid-operation: pending returns cancelled (dispValid/hostRdValid = 0 on the cycle after reset). hostStallCnt cleared.

Optional Feature:
- Macro: GLYPH_BLANK_WRITE_EN.
- Defined: a head-of-FIFO write is popped only when compBlank=1 (tear-free glyph update).
  - A write at the head blocks later commands in order until blanking.
  - Host reads at the head still drain in active video.
- Not defined: compBlank is ignored; the port remains present.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults; grant encoding GNT_NONE=2'd0, GNT_DISP=2'd1, GNT_HOST=2'd2; host command record width (1 + ADDR_W + DATA_W).
- One sub-module: host_cmd_fifo.
  - Synchronous FIFO, FIFO_DEPTH entries.
  - Ports: push/pop, full/empty, head data.
  - Synchronous active-high reset.

Test Plan:
1. Display read addr 0x123 at N, memory model returns 0xA5 -> dispValid=1 and dispByte=0xA5 at N+2; memWe=0 throughout.
2. Host write 0x045<-0x3C with dispReadEn=0 -> memEn=memWe=1, memAddr=0x045 the next cycle. A following host read 0x045 -> hostRdValid pulse with 0x3C.
3. dispReadEn=1 for 20 cycles, host pushes 6 commands -> 4 accepted, hostReady=0 after the 4th, hostStallCnt counts stalled cycles. Drain starts on the first cycle dispReadEn=0; commands execute in order.
4. Host write and display read of the same address in the same cycle -> display granted and gets old data; the write executes the next free cycle.
5. Reset asserted while a host read is in flight (1 cycle after grant) -> no hostRdValid, FIFO empty, hostReady=1 after release.
6. With GLYPH_BLANK_WRITE_EN, host write queued at compBlank=0 -> memWe stays 0 until compBlank=1, then issues in that cycle. Without the macro it issues immediately.
